multdiv_ctrl: RTL and testbench

- Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline.
- Detects a mul/div in DX and freezes PC, FD and DX while the unit runs.
- Holds the operands and start pulse to the unit, waits for its ready, then injects the result (or an exception code for $r30) into XM in place of the ALU result.
- Sits beside the ALU in the X stage; the regfile writeback path is unchanged.

---
 rtl/multdiv_ctrl.sv | 145 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences the multi-cycle multiply/divide unit in the X stage.
// A mul/div sitting in DX freezes PC/FD/DX. The controller latches the
// operands, pulses the unit's start line and waits for md_ready. It then
// hands XM either the unit result or an exception code aimed at $r30.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   dx_valid/is_mul/is_div  DX instruction qualifiers
//   dx_a, dx_b, dx_rd       bypassed operands and destination register
//   md_ctrl_mult/div        one-cycle start pulses to the unit
//   md_op_a, md_op_b        operands held for the unit
//   md_result/exception     unit response, qualified by md_ready
//   stall                   freeze PC/FD/DX, bubble XM
//   busy                    controller not idle
//   res_valid/data/rd/exc   one-cycle result injected into XM
//
// state  | meaning
// IDLE   | watching DX for a mul/div; stall is raised combinationally on detect
// START  | start pulse to the unit, operands held, counter cleared
// WAIT   | counting cycles until md_ready or timeout
// DONE   | result presented to XM, stall released so DX advances
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT      = 40,
    parameter int unsigned MUL_EXC_CODE = 4,
    parameter int unsigned DIV_EXC_CODE = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_valid,
    input  logic        dx_is_mul,
    input  logic        dx_is_div,
    input  logic [31:0] dx_a,
    input  logic [31:0] dx_b,
    input  logic [4:0]  dx_rd,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_op_a,
    output logic [31:0] md_op_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        stall,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        res_exc
);

    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [31:0] MUL_CODE = 32'(MUL_EXC_CODE);
    localparam logic [31:0] DIV_CODE = 32'(DIV_EXC_CODE);
    localparam logic [4:0]  EXC_RD   = 5'd30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic        op_mul_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt;

    logic go;
    logic timeout;
    logic fin_exc;

    assign go      = dx_valid & (dx_is_mul | dx_is_div);
    assign timeout = (cnt == TO_LAST);
    // md_ready has priority over a coincident timeout.
    assign fin_exc = md_ready ? md_exception : 1'b1;

    assign stall   = ((state == S_IDLE) & go) | (state == S_START) | (state == S_WAIT);
    assign busy    = (state != S_IDLE);
    assign md_op_a = op_a_q;
    assign md_op_b = op_b_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_mul_q     <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rd_q         <= '0;
            cnt          <= '0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_rd       <= '0;
            res_exc      <= 1'b0;
        end else begin
            // Pulses and result fields are single-cycle; default them low.
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_rd       <= '0;
            res_exc      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        op_a_q       <= dx_a;
                        op_b_q       <= dx_b;
                        rd_q         <= dx_rd;
                        op_mul_q     <= dx_is_mul;
                        md_ctrl_mult <= dx_is_mul;
                        md_ctrl_div  <= ~dx_is_mul;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (md_ready || timeout) begin
                        res_valid <= 1'b1;
                        res_exc   <= fin_exc;
                        res_rd    <= fin_exc ? EXC_RD : rd_q;
                        if (fin_exc)
                            res_data <= op_mul_q ? MUL_CODE : DIV_CODE;
                        else
                            res_data <= md_result;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: drives mul/div instructions into multdiv_ctrl and plays
// the role of the arithmetic unit. Expected timing and results come from a
// transaction-level model: an op whose unit answers after N wait cycles
// stalls for N+2 cycles, then presents one DONE cycle. A timeout stalls for
// TIMEOUT+2 cycles and ends in an exception.
module tb_multdiv_ctrl;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        dx_valid, dx_is_mul, dx_is_div;
    logic [31:0] dx_a, dx_b;
    logic [4:0]  dx_rd;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_op_a, md_op_b;
    logic [31:0] md_result;
    logic        md_exception, md_ready;
    logic        stall, busy, res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_exc;

    int checks = 0;
    int errors = 0;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT), .MUL_EXC_CODE(4), .DIV_EXC_CODE(5)) dut (
        .clock(clock), .reset(reset),
        .dx_valid(dx_valid), .dx_is_mul(dx_is_mul), .dx_is_div(dx_is_div),
        .dx_a(dx_a), .dx_b(dx_b), .dx_rd(dx_rd),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_op_a(md_op_a), .md_op_b(md_op_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .stall(stall), .busy(busy), .res_valid(res_valid),
        .res_data(res_data), .res_rd(res_rd), .res_exc(res_exc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_dx(input logic v, input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        dx_valid  = v;
        dx_is_mul = m;
        dx_is_div = d;
        dx_a      = a;
        dx_b      = b;
        dx_rd     = rd;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mult"}, 32'(md_ctrl_mult), 32'd0);
        chk({tag, "_div"}, 32'(md_ctrl_div), 32'd0);
        chk({tag, "_rvalid"}, 32'(res_valid), 32'd0);
        chk({tag, "_rdata"}, res_data, 32'd0);
    endtask

    // One idle cycle: a bubble (v=0) or a non-mul/div instruction (v=1).
    task automatic idle_cycle(input logic v);
        drive_dx(v, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom));
        md_ready = 1'b0;
        #4;
        check_quiet(v ? "idle_alu" : "idle_bubble");
        @(negedge clock);
    endtask

    // One complete mul/div transaction, starting at a negedge with the
    // controller idle. n = wait cycles before the unit answers (0 = never).
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int n, input bit early);
        logic        op_mul;
        logic [31:0] u_res;
        logic        u_exc;
        logic        e_exc;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        int          dk;
        op_mul = m;
        u_exc  = !op_mul && (b == 32'd0);
        u_res  = op_mul ? a * b : (u_exc ? 32'd0 : a / b);
        dk     = (n > 0) ? 2 + n : 2 + TIMEOUT;
        e_exc  = (n > 0) ? u_exc : 1'b1;
        e_data = e_exc ? (op_mul ? 32'd4 : 32'd5) : u_res;
        e_rd   = e_exc ? 5'd30 : rd;
        for (int k = 0; k <= dk; k++) begin
            drive_dx(1'b1, m, d, a, b, rd);
            if (n > 0 && k == 1 + n) begin
                md_ready     = 1'b1;
                md_result    = u_res;
                md_exception = u_exc;
            end else begin
                md_ready     = (early && k == 1) ? 1'b1 : 1'b0;
                md_result    = $urandom;
                md_exception = 1'($urandom);
            end
            #4;
            chk({tag, "_stall"}, 32'(stall), 32'(k < dk));
            chk({tag, "_busy"}, 32'(busy), 32'(k >= 1));
            chk({tag, "_mult"}, 32'(md_ctrl_mult), 32'(k == 1 && op_mul));
            chk({tag, "_div"}, 32'(md_ctrl_div), 32'(k == 1 && !op_mul));
            chk({tag, "_rvalid"}, 32'(res_valid), 32'(k == dk));
            if (k >= 1) begin
                chk({tag, "_opa"}, md_op_a, a);
                chk({tag, "_opb"}, md_op_b, b);
            end
            if (k == dk) begin
                chk({tag, "_rdata"}, res_data, e_data);
                chk({tag, "_rrd"}, 32'(res_rd), 32'(e_rd));
                chk({tag, "_rexc"}, 32'(res_exc), 32'(e_exc));
            end else begin
                chk({tag, "_rdata0"}, res_data, 32'd0);
                chk({tag, "_rexc0"}, 32'(res_exc), 32'd0);
            end
            @(negedge clock);
        end
        md_ready = 1'b0;
    endtask

    initial begin
        logic        rm, rd_div;
        logic [31:0] ra, rb;
        reset = 1'b1;
        drive_dx(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        md_ready     = 1'b0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        repeat (2) @(negedge clock);
        check_quiet("reset");
        chk("reset_opa", md_op_a, 32'd0);
        chk("reset_rrd", 32'(res_rd), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_op("mul7x6", 1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 3, 1'b0);
        idle_cycle(1'b0);
        run_op("div10by0", 1'b0, 1'b1, 32'd10, 32'd0, 5'd8, 2, 1'b0);
        run_op("mul_timeout", 1'b1, 1'b0, 32'd123, 32'd456, 5'd9, 0, 1'b0);
        run_op("b2b_mul", 1'b1, 1'b0, 32'd11, 32'd13, 5'd5, 1, 1'b0);
        run_op("b2b_div", 1'b0, 1'b1, 32'd100, 32'd7, 5'd6, 2, 1'b0);
        idle_cycle(1'b1);
        run_op("div_rd0", 1'b0, 1'b1, 32'd50, 32'd5, 5'd0, 1, 1'b0);

        // Reset in the middle of WAIT abandons the operation.
        drive_dx(1'b1, 1'b1, 1'b0, 32'd9, 32'd9, 5'd4);
        #4;
        chk("rst_detect_stall", 32'(stall), 32'd1);
        @(negedge clock);
        #4;
        chk("rst_start_mult", 32'(md_ctrl_mult), 32'd1);
        @(negedge clock);
        @(negedge clock);
        drive_dx(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        #1 reset = 1'b1;
        #1;
        check_quiet("rst_mid");
        chk("rst_mid_opa", md_op_a, 32'd0);
        @(negedge clock);
        reset        = 1'b0;
        md_ready     = 1'b1;
        md_result    = 32'hdead_beef;
        md_exception = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("rst_late_ready_rvalid", 32'(res_valid), 32'd0);
            chk("rst_late_ready_busy", 32'(busy), 32'd0);
            @(negedge clock);
        end
        md_ready = 1'b0;
        run_op("mul_after_rst", 1'b1, 1'b0, 32'd9, 32'd9, 5'd4, 2, 1'b0);

        run_op("early_ready", 1'b1, 1'b0, 32'd3, 32'd5, 5'd12, 3, 1'b1);
        idle_cycle(1'b1);
        run_op("both_flags", 1'b1, 1'b1, 32'd21, 32'd2, 5'd17, 1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            rm     = 1'($urandom);
            rd_div = !rm | 1'($urandom);
            ra     = $urandom;
            rb     = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_op("rand", rm, rd_div, ra, rb, 5'($urandom), int'($urandom_range(1, 6)),
                   1'($urandom));
            if ($urandom_range(0, 1) == 1)
                idle_cycle(1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
